// File: rtl/detector_scheduler.sv
// detector_scheduler
//   Time-shares one 01[0*]1 sequence detector between NUM_REQ requesters.
//   A round-robin arbiter accepts one WORD_W-bit word. The detector is
//   held in reset for one cycle, and the word is streamed into it
//   MSB-first for WORD_W cycles. The z hits are counted, and the count is
//   returned with the requester id on a valid/ready response port.
//
// Ports
//   clk, rst          clock (rising edge), async active-high reset
//   req_valid_i       per-requester word valid
//   req_data_i        requester i word at [i*WORD_W +: WORD_W]
//   req_ready_o       one-hot accept, only in IDLE
//   det_rst_o         detector reset (IDLE/CLEAR)
//   det_ena_o         detector enable (STREAM)
//   det_sig_o         detector input bit (STREAM)
//   det_z_i           detector Mealy output, counted during STREAM
//   resp_valid_o      result available (REPORT)
//   resp_id_o         requester id of result
//   resp_count_o      number of z hits during the stream
//   resp_ready_i      consumer accepts result
//   busy_o            high in any state but IDLE
module detector_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WORD_W  = 16,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = $clog2(WORD_W + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*WORD_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      det_rst_o,
    output logic                      det_ena_o,
    output logic                      det_sig_o,
    input  logic                      det_z_i,
    output logic                      resp_valid_o,
    output logic [ID_W-1:0]           resp_id_o,
    output logic [CNT_W-1:0]          resp_count_o,
    input  logic                      resp_ready_i,
    output logic                      busy_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CLEAR  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  idx_q, idx_d;

    logic              grant_any;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   winner_nxt;
    logic              accept;
    int                arb_idx;

    // Scan from the highest priority offset down, so that the
    // lowest offset from rr_q holds the final assignment.
    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        arb_idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            arb_idx = (int'(rr_q) + k) % NUM_REQ;
            if (req_valid_i[arb_idx]) begin
                grant_any = 1'b1;
                winner    = ID_W'(arb_idx);
            end
        end
    end

    assign winner_nxt = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    assign accept     = (state_q == S_IDLE) && grant_any;

    // While reset is asserted, nothing may be accepted. Gate the reset
    // into the combinational ready as well.
    always_comb begin
        req_ready_o = '0;
        if (accept && !rst) req_ready_o[winner] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shift_d = req_data_i[winner*WORD_W +: WORD_W];
                    id_d    = winner;
                    rr_d    = winner_nxt;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                shift_d = {shift_q[WORD_W-2:0], 1'b0};
                idx_d   = idx_q + 1'b1;
                if (det_z_i) cnt_d = cnt_q + 1'b1;
                if (idx_q == CNT_W'(WORD_W - 1)) state_d = S_REPORT;
            end
            default: begin
                if (resp_ready_i) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // All outputs are decoded from registered state only. det_z_i has no
    // path to any output.
    assign det_rst_o    = (state_q == S_IDLE) || (state_q == S_CLEAR);
    assign det_ena_o    = (state_q == S_STREAM);
    assign det_sig_o    = det_ena_o & shift_q[WORD_W-1];
    assign resp_valid_o = (state_q == S_REPORT);
    assign resp_id_o    = id_q;
    assign resp_count_o = cnt_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_detector_scheduler.sv
module tb_detector_scheduler;
    localparam int NUM_REQ = 4;
    localparam int WORD_W  = 16;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 5;

    logic                      clk, rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*WORD_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic                      det_rst_o, det_ena_o, det_sig_o, det_z;
    logic                      resp_valid_o, resp_ready;
    logic [ID_W-1:0]           resp_id_o;
    logic [CNT_W-1:0]          resp_count_o;
    logic                      busy_o;

    detector_scheduler #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready_o),
        .det_rst_o(det_rst_o), .det_ena_o(det_ena_o), .det_sig_o(det_sig_o),
        .det_z_i(det_z),
        .resp_valid_o(resp_valid_o), .resp_id_o(resp_id_o), .resp_count_o(resp_count_o),
        .resp_ready_i(resp_ready), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {int id; int cnt;} exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference model: transaction-level view (free/busy, age since accept)
    bit                 free = 1'b1;
    int                 age  = 0;
    int                 rr   = 0;
    logic [WORD_W-1:0]  cur_word, cur_z;
    bit                 force_en = 1'b0;
    logic [WORD_W-1:0]  force_pat;
    bit                 last_acc, dut_acc;
    int                 last_win;
    logic [NUM_REQ-1:0] acc_ready;
    int                 cyc = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int arb(logic [NUM_REQ-1:0] v, int p);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return -1;
    endfunction

    // One clock cycle: drive det_z, check all outputs, advance model.
    // Called right after a falling edge; returns at the next falling edge.
    task automatic step();
        int win;
        bit stream, exp_rv, hs;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [WORD_W-1:0] w;
        if (rst) begin free = 1'b1; age = 0; rr = 0; sb.delete(); end
        stream = !free && age >= 2 && age <= WORD_W + 1;
        det_z = stream ? cur_z[age-2] : 1'($urandom_range(0, 1));
        #1;
        win = arb(req_valid, rr);
        exp_rdy = '0;
        if (free && !rst && win >= 0) exp_rdy[win] = 1'b1;
        exp_rv = !free && age >= WORD_W + 2;
        chk("req_ready", 32'(req_ready_o), 32'(exp_rdy));
        chk("busy", 32'(busy_o), 32'(!free));
        chk("det_rst", 32'(det_rst_o), 32'(free || age == 1));
        chk("det_ena", 32'(det_ena_o), 32'(stream));
        chk("det_sig", 32'(det_sig_o), stream ? 32'(cur_word[WORD_W+1-age]) : 32'd0);
        chk("resp_valid", 32'(resp_valid_o), 32'(exp_rv));
        if (rst) begin
            chk("rst_resp_id", 32'(resp_id_o), 32'd0);
            chk("rst_resp_count", 32'(resp_count_o), 32'd0);
        end
        acc_ready = req_ready_o;
        dut_acc   = |(req_ready_o & req_valid);
        last_acc  = free && !rst && win >= 0;
        last_win  = win;
        hs        = exp_rv && resp_ready;
        w         = '0;
        if (last_acc) w = req_data[win*WORD_W +: WORD_W];
        @(posedge clk);
        cyc++;
        if (!rst) begin
            if (last_acc) begin
                free = 1'b0; age = 1; cur_word = w;
                if (force_en) begin cur_z = force_pat; force_en = 1'b0; end
                else case ($urandom_range(0, 3))
                    0: cur_z = '1;
                    1: cur_z = '0;
                    default: cur_z = WORD_W'($urandom);
                endcase
                rr = (win + 1) % NUM_REQ;
                sb.push_back('{win, $countones(cur_z)});
            end else if (!free) begin
                if (hs) begin free = 1'b1; age = 0; end
                else if (age < WORD_W + 2) age++;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (!(free && sb.size() == 0) && n < budget) begin
            step();
            if (last_acc) req_valid[last_win] = 1'b0;
            n++;
        end
        checks++;
        if (!(free && sb.size() == 0)) begin
            errors++;
            $display("FAIL drain_timeout pending %0d expected 0", sb.size());
        end
    endtask

    // Scoreboard monitor: compare the presented response with the queue head;
    // pop on handshake. Checking while stalled also proves stability.
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst && resp_valid_o) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp_unexpected id %0d count %0d expected none", resp_id_o, resp_count_o);
            end else begin
                chk("resp_id", 32'(resp_id_o), 32'(sb[0].id));
                chk("resp_count", 32'(resp_count_o), 32'(sb[0].cnt));
                if (resp_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        int first, n, prev, budget;
        rst = 1'b1; req_valid = '0; req_data = '0; resp_ready = 1'b0; det_z = 1'b0;
        @(negedge clk);
        req_valid = '1;               // no accept may happen under reset
        repeat (3) step();
        rst = 1'b0; req_valid = '0;

        // Single request, word 4800, one z hit on stream bit 4
        req_data[WORD_W-1:0] = 16'h4800;
        req_valid = 4'b0001; resp_ready = 1'b1;
        force_en = 1'b1; force_pat = 16'h0010;
        step();
        chk("t1_grant", 32'(acc_ready), 32'h1);
        req_valid = '0;
        drain(40);

        // Round robin with all valid held: strict rotation, 19-cycle spacing
        first = rr; n = 0; prev = 0; budget = 0;
        req_valid = '1; req_data = {$urandom, $urandom};
        while (n < 8 && budget < 300) begin
            step(); budget++;
            if (dut_acc) begin
                chk("rr_order", 32'(acc_ready), 32'(1 << ((first + n) % NUM_REQ)));
                if (n > 0) chk("b2b_gap", 32'(cyc - prev), 32'(WORD_W + 3));
                prev = cyc; n++;
            end
        end
        chk("rr_grants", 32'(n), 32'd8);
        req_valid = '0;
        drain(40);

        // Count extremes
        force_en = 1'b1; force_pat = '1;
        req_valid = 4'b0100; step(); req_valid = '0; drain(40);
        force_en = 1'b1; force_pat = '0;
        req_valid = 4'b1000; step(); req_valid = '0; drain(40);

        // Backpressure: 10 stalled cycles in REPORT, accept right after release
        resp_ready = 1'b0; req_valid = 4'b0001; step(); req_valid = '0;
        budget = 0;
        while (age < WORD_W + 2 && budget < 40) begin step(); budget++; end
        req_valid = '1;
        repeat (10) step();
        resp_ready = 1'b1; step();
        step();
        chk("bp_accept_after", 32'(dut_acc), 32'd1);
        req_valid = '0;
        drain(40);

        // Reset in the middle of the stream (bit 7)
        req_valid = 4'b0010; step(); req_valid = '0;
        budget = 0;
        while (age < 9 && budget < 40) begin step(); budget++; end
        rst = 1'b1; step();
        rst = 1'b0; req_valid = '1; step();
        chk("rst_rr_zero", 32'(acc_ready), 32'h1);
        req_valid = '0;
        drain(40);

        // rr_ptr=3 with requesters 1 and 2 valid -> 1; then 2 follows
        req_valid = 4'b0100; step(); req_valid = '0; drain(40);
        req_valid = 4'b0110; step();
        chk("sim_grant1", 32'(acc_ready), 32'h2);
        req_valid = '0; drain(40);
        req_valid = '1; step();
        chk("sim_grant2", 32'(acc_ready), 32'h4);
        req_valid = '0; drain(40);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*WORD_W +: WORD_W] = WORD_W'($urandom);
                end else if (req_valid[i] && $urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
            if (last_acc) req_valid[last_win] = 1'b0;
        end
        req_valid = '0; resp_ready = 1'b1;
        drain(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
